txn_mem: RTL

TXN_MEM -- requirements
Module: txn_mem

---
 rtl/txn_mem.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/txn_mem.sv
// Two-bank word memory behind a single-outstanding request/ready port with fixed busy latency.
// Optional macro TXN_MEM_ERR_EN: flag misaligned or unmapped addresses instead of aliasing them.
module txn_mem #(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 128,
    parameter logic [31:0] RD_BASE   = 32'h4000_0000,
    parameter logic [31:0] WR_BASE   = 32'h4000_1000,
    parameter int          RD_LAT    = 16,
    parameter int          WR_LAT    = 16,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              txn_req,
    input  logic              txn_wr,
    input  logic [31:0]       txn_addr,
    input  logic [DATA_W-1:0] txn_wdata,
    output logic [DATA_W-1:0] txn_rdata,
    output logic              txn_rdy,
    output logic              txn_err,
    output logic [31:0]       cnt_rd,
    output logic [31:0]       cnt_wr,
    output logic              dbg_state
);

    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] BYTES_L = 32'(DATA_W / 8);
    localparam logic [31:0] DEPTH_L = 32'(DEPTH);
    localparam logic [31:0] SPAN    = 32'(DEPTH * (DATA_W / 8));

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_cnt;
    logic                r_wr;
    logic                r_bank;
    logic [IDX_W-1:0]    r_idx;
    logic                r_bad;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [31:0]         r_cnt_rd;
    logic [31:0]         r_cnt_wr;
    logic [DATA_W-1:0]   r_bank0 [DEPTH];
    logic [DATA_W-1:0]   r_bank1 [DEPTH];

    logic                w_accept;
    logic                w_complete;
    logic                w_done;
    logic [31:0]         w_off0;
    logic [31:0]         w_off1;
    logic [31:0]         w_off;
    logic                w_bank;
    logic                w_bad;
    logic [IDX_W-1:0]    w_idx;

    // Address decode happens on the request, so the error case can skip the latency.
    assign w_off0 = txn_addr - RD_BASE;
    assign w_off1 = txn_addr - WR_BASE;
`ifdef TXN_MEM_ERR_EN
    logic w_in0;
    logic w_in1;
    assign w_in0  = (w_off0 < SPAN);
    assign w_in1  = (w_off1 < SPAN);
    assign w_bank = w_in1;
    assign w_bad  = !(w_in0 || w_in1) || ((txn_addr % BYTES_L) != 32'd0);
`else
    assign w_bank = (txn_addr >= WR_BASE);
    assign w_bad  = 1'b0;
`endif
    assign w_off = w_bank ? w_off1 : w_off0;
    assign w_idx = IDX_W'((w_off / BYTES_L) % DEPTH_L);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (txn_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt == 8'd0) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_done = w_complete && !r_bad;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 8'd0;
            r_wr     <= 1'b0;
            r_bank   <= 1'b0;
            r_idx    <= '0;
            r_bad    <= 1'b0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_cnt_rd <= 32'd0;
            r_cnt_wr <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_wr    <= txn_wr;
                r_bank  <= w_bank;
                r_idx   <= w_idx;
                r_bad   <= w_bad;
                r_wdata <= txn_wdata;
                r_cnt   <= w_bad ? 8'd0 : (txn_wr ? 8'(WR_LAT) : 8'(RD_LAT));
            end else if (r_state == ST_BUSY && r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_done && !r_wr) begin
                r_rdata <= r_bank ? r_bank1[r_idx] : r_bank0[r_idx];
                if (r_cnt_rd != 32'hFFFF_FFFF) r_cnt_rd <= r_cnt_rd + 32'd1;
            end
            if (w_done && r_wr && r_cnt_wr != 32'hFFFF_FFFF) begin
                r_cnt_wr <= r_cnt_wr + 32'd1;
            end
        end
    end

    // Storage has no reset; reset forces IDLE so no completion can write during it.
    always_ff @(posedge clk) begin
        if (w_done && r_wr) begin
            if (r_bank) r_bank1[r_idx] <= r_wdata;
            else        r_bank0[r_idx] <= r_wdata;
        end
    end

`ifdef TXN_MEM_ERR_EN
    logic r_err;
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) r_err <= 1'b0;
        else         r_err <= w_complete && r_bad;
    end
    assign txn_err = r_err;
`else
    assign txn_err = 1'b0;
`endif

    assign txn_rdy   = (r_state == ST_IDLE);
    assign txn_rdata = r_rdata;
    assign cnt_rd    = r_cnt_rd;
    assign cnt_wr    = r_cnt_wr;
    assign dbg_state = r_state;

endmodule
